countdown_sequencer: RTL and testbench

Control FSM for the countdown datapath. Runs on the logic clock and takes the keypad key-down levels, the 4-bit key value and the 1 Hz tick square wave. Produces the entered amount, the remaining count and the display enable that feed the decimal splitters and the 4-digit display. Sequences power-on, digit entry, running, pause and expiry.

---
 rtl/countdown_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Countdown control FSM: keypad/tick edge detection, two-digit entry, run/pause/expiry sequencing.
// Optional build macro COUNTDOWN_BLINK_EN: display toggles on each tick while in DONE.
module countdown_sequencer #(
    parameter int WIDTH   = 7,
    parameter int MAX_VAL = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             keydown_start,
    input  logic             keydown_confirm,
    input  logic             keydown_clear,
    input  logic             keydown_num,
    input  logic [3:0]       num,
    input  logic             tick,
    output logic             display,
    output logic [WIDTH-1:0] input_val,
    output logic [WIDTH-1:0] remaining,
    output logic [2:0]       state,
    output logic             done
);

    // state    | meaning
    // ST_OFF   | powered up, waiting for start; display dark
    // ST_ENTRY | collecting up to two decimal digits into input_val
    // ST_RUN   | remaining decrements on each tick rising edge
    // ST_PAUSE | ticks ignored, remaining held
    // ST_DONE  | count expired; confirm repeats, clear re-enters
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_START,
        EV_CLEAR,
        EV_CONFIRM,
        EV_NUM,
        EV_TICK
    } event_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] input_val_q, input_val_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             display_q, display_d;

    logic start_prev_q, confirm_prev_q, clear_prev_q, num_prev_q, tick_prev_q;

    event_t      ev;
    logic [31:0] cand;
    logic        cand_ok;

    // Previous samples reset high so levels held through reset need a low first.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q   <= 1'b1;
            confirm_prev_q <= 1'b1;
            clear_prev_q   <= 1'b1;
            num_prev_q     <= 1'b1;
            tick_prev_q    <= 1'b1;
        end else begin
            start_prev_q   <= keydown_start;
            confirm_prev_q <= keydown_confirm;
            clear_prev_q   <= keydown_clear;
            num_prev_q     <= keydown_num;
            tick_prev_q    <= tick;
        end
    end

    always_comb begin
        ev = EV_NONE;
        if (keydown_start && !start_prev_q) begin
            ev = EV_START;
        end else if (keydown_clear && !clear_prev_q) begin
            ev = EV_CLEAR;
        end else if (keydown_confirm && !confirm_prev_q) begin
            ev = EV_CONFIRM;
        end else if (keydown_num && !num_prev_q) begin
            ev = EV_NUM;
        end else if (tick && !tick_prev_q) begin
            ev = EV_TICK;
        end
    end

    // Shift the ones digit up into the tens place and append the new digit.
    always_comb begin
        cand    = ((32'(input_val_q) % 32'd10) * 32'd10) + 32'(num);
        cand_ok = (num <= 4'd9) && (cand <= 32'(MAX_VAL));
    end

    always_comb begin
        state_d     = state_q;
        input_val_d = input_val_q;
        remaining_d = remaining_q;

        if (ev == EV_START) begin
            state_d     = ST_ENTRY;
            input_val_d = '0;
            remaining_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_OFF;
                end
                ST_ENTRY: begin
                    case (ev)
                        EV_NUM: begin
                            if (cand_ok) begin
                                input_val_d = WIDTH'(cand);
                            end
                        end
                        EV_CLEAR: begin
                            input_val_d = '0;
                        end
                        EV_CONFIRM: begin
                            if (input_val_q != '0) begin
                                remaining_d = input_val_q;
                                state_d     = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    case (ev)
                        EV_TICK: begin
                            remaining_d = remaining_q - WIDTH'(1);
                            if (remaining_q == WIDTH'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                        EV_CONFIRM: begin
                            state_d = ST_PAUSE;
                        end
                        EV_CLEAR: begin
                            state_d     = ST_ENTRY;
                            input_val_d = '0;
                            remaining_d = '0;
                        end
                        default: ;
                    endcase
                end
                ST_PAUSE: begin
                    case (ev)
                        EV_CONFIRM: begin
                            state_d = ST_RUN;
                        end
                        EV_CLEAR: begin
                            state_d     = ST_ENTRY;
                            input_val_d = '0;
                            remaining_d = '0;
                        end
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    remaining_d = '0;
                    case (ev)
                        EV_CLEAR: begin
                            state_d     = ST_ENTRY;
                            input_val_d = '0;
                        end
                        EV_CONFIRM: begin
                            state_d     = ST_RUN;
                            remaining_d = input_val_q;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state_d     = ST_OFF;
                    input_val_d = '0;
                    remaining_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        display_d = (state_d != ST_OFF);
`ifdef COUNTDOWN_BLINK_EN
        // Arrival in DONE shows lit; only ticks while already in DONE toggle.
        if (state_q == ST_DONE && state_d == ST_DONE) begin
            display_d = (ev == EV_TICK) ? ~display_q : display_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            input_val_q <= '0;
            remaining_q <= '0;
            display_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            input_val_q <= input_val_d;
            remaining_q <= remaining_d;
            display_q   <= display_d;
        end
    end

    assign state     = state_q;
    assign done      = (state_q == ST_DONE);
    assign input_val = input_val_q;
    assign remaining = remaining_q;
    assign display   = display_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer; a second instance with MAX_VAL=50 shares the stimulus.
module tb_countdown_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       keydown_start = 1'b0;
    logic       keydown_confirm = 1'b0;
    logic       keydown_clear = 1'b0;
    logic       keydown_num = 1'b0;
    logic [3:0] num = 4'd0;
    logic       tick = 1'b0;

    logic       display, done;
    logic [6:0] input_val, remaining;
    logic [2:0] state;

    logic       display50, done50;
    logic [6:0] input_val50, remaining50;
    logic [2:0] state50;

    int checks = 0;
    int failures = 0;

    countdown_sequencer #(.WIDTH(7), .MAX_VAL(99)) dut (
        .clk(clk), .rst(rst),
        .keydown_start(keydown_start), .keydown_confirm(keydown_confirm),
        .keydown_clear(keydown_clear), .keydown_num(keydown_num),
        .num(num), .tick(tick),
        .display(display), .input_val(input_val), .remaining(remaining),
        .state(state), .done(done)
    );

    countdown_sequencer #(.WIDTH(7), .MAX_VAL(50)) dut50 (
        .clk(clk), .rst(rst),
        .keydown_start(keydown_start), .keydown_confirm(keydown_confirm),
        .keydown_clear(keydown_clear), .keydown_num(keydown_num),
        .num(num), .tick(tick),
        .display(display50), .input_val(input_val50), .remaining(remaining50),
        .state(state50), .done(done50)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_num(input logic [3:0] v);
        keydown_num = 1'b1; num = v; step();
        keydown_num = 1'b0; step();
    endtask

    task automatic press_start();
        keydown_start = 1'b1; step();
        keydown_start = 1'b0; step();
    endtask

    task automatic press_clear();
        keydown_clear = 1'b1; step();
        keydown_clear = 1'b0; step();
    endtask

    task automatic press_confirm();
        keydown_confirm = 1'b1; step();
        keydown_confirm = 1'b0; step();
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b1; keydown_start = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (display !== 1'b0) begin failures++; $display("FAIL reset_display got=%b exp=0", display); end
        checks++; if (input_val !== 7'd0 || remaining !== 7'd0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_values input_val=%0d remaining=%0d done=%b exp=0/0/0", input_val, remaining, done);
        end
        step();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL held_start got=%0d exp=0", state); end
        keydown_start = 1'b0; step();
        keydown_start = 1'b1; step();
        checks++; if (state !== 3'd1 || display !== 1'b1) begin
            failures++; $display("FAIL start_entry state=%0d display=%b exp=1/1", state, display);
        end
        keydown_start = 1'b0; step();
    endtask

    task automatic test_entry();
        logic [6:0] exp99 [3];
        logic [6:0] exp50 [3];
        logic [3:0] keys  [3];
        keys  = '{4'd4, 4'd7, 4'd3};
        exp99 = '{7'd4, 7'd47, 7'd73};
        exp50 = '{7'd4, 7'd47, 7'd47};
        for (int i = 0; i < 3; i++) begin
            press_num(keys[i]);
            checks++; if (input_val !== exp99[i]) begin
                failures++; $display("FAIL entry_digit%0d got=%0d exp=%0d", i, input_val, exp99[i]);
            end
            checks++; if (input_val50 !== exp50[i]) begin
                failures++; $display("FAIL entry50_digit%0d got=%0d exp=%0d", i, input_val50, exp50[i]);
            end
        end
        press_num(4'd12);
        checks++; if (input_val !== 7'd73) begin failures++; $display("FAIL num_gt9 got=%0d exp=73", input_val); end
        press_clear();
        checks++; if (input_val !== 7'd0) begin failures++; $display("FAIL entry_clear got=%0d exp=0", input_val); end
        press_confirm();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL confirm_zero state=%0d exp=1", state); end
    endtask

    task automatic test_run_to_expiry();
        logic [6:0] exp_rem [3];
        logic       exp_disp [3];
        exp_rem = '{7'd2, 7'd1, 7'd0};
`ifdef COUNTDOWN_BLINK_EN
        exp_disp = '{1'b0, 1'b1, 1'b0};
`else
        exp_disp = '{1'b1, 1'b1, 1'b1};
`endif
        press_num(4'd0);
        press_num(4'd3);
        checks++; if (input_val !== 7'd3) begin failures++; $display("FAIL enter_03 got=%0d exp=3", input_val); end
        press_confirm();
        checks++; if (state !== 3'd2 || remaining !== 7'd3) begin
            failures++; $display("FAIL run_start state=%0d remaining=%0d exp=2/3", state, remaining);
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; step();
            checks++; if (remaining !== exp_rem[i]) begin
                failures++; $display("FAIL run_tick%0d remaining=%0d exp=%0d", i, remaining, exp_rem[i]);
            end
            tick = 1'b0; step();
        end
        checks++; if (state !== 3'd4 || done !== 1'b1 || display !== 1'b1) begin
            failures++; $display("FAIL expiry state=%0d done=%b display=%b exp=4/1/1", state, done, display);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            checks++; if (state !== 3'd4 || remaining !== 7'd0 || display !== exp_disp[i]) begin
                failures++; $display("FAIL done_tick%0d state=%0d remaining=%0d display=%b exp=4/0/%b",
                                     i, state, remaining, display, exp_disp[i]);
            end
        end
    endtask

    task automatic test_pause_collision();
        press_clear();
        checks++; if (state !== 3'd1 || input_val !== 7'd0 || display !== 1'b1) begin
            failures++; $display("FAIL done_clear state=%0d input_val=%0d display=%b exp=1/0/1", state, input_val, display);
        end
        press_num(4'd1);
        press_num(4'd0);
        press_confirm();
        checks++; if (state !== 3'd2 || remaining !== 7'd10) begin
            failures++; $display("FAIL run10 state=%0d remaining=%0d exp=2/10", state, remaining);
        end
        keydown_confirm = 1'b1; tick = 1'b1; step();
        checks++; if (state !== 3'd3 || remaining !== 7'd10) begin
            failures++; $display("FAIL pause_collision state=%0d remaining=%0d exp=3/10", state, remaining);
        end
        keydown_confirm = 1'b0; tick = 1'b0; step();
        for (int i = 0; i < 5; i++) pulse_tick();
        checks++; if (state !== 3'd3 || remaining !== 7'd10) begin
            failures++; $display("FAIL pause_hold state=%0d remaining=%0d exp=3/10", state, remaining);
        end
        press_confirm();
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL resume state=%0d exp=2", state); end
        pulse_tick();
        checks++; if (remaining !== 7'd9) begin failures++; $display("FAIL resume_tick remaining=%0d exp=9", remaining); end
    endtask

    task automatic test_priority_reload();
        press_clear();
        checks++; if (state !== 3'd1 || input_val !== 7'd0 || remaining !== 7'd0) begin
            failures++; $display("FAIL run_clear state=%0d input_val=%0d remaining=%0d exp=1/0/0", state, input_val, remaining);
        end
        press_num(4'd1);
        press_num(4'd2);
        press_confirm();
        for (int i = 0; i < 12; i++) pulse_tick();
        checks++; if (state !== 3'd4 || input_val !== 7'd12 || remaining !== 7'd0) begin
            failures++; $display("FAIL done12 state=%0d input_val=%0d remaining=%0d exp=4/12/0", state, input_val, remaining);
        end
        press_confirm();
        checks++; if (state !== 3'd2 || remaining !== 7'd12) begin
            failures++; $display("FAIL reload state=%0d remaining=%0d exp=2/12", state, remaining);
        end
        for (int i = 0; i < 12; i++) pulse_tick();
        keydown_start = 1'b1; keydown_clear = 1'b1; keydown_confirm = 1'b1; step();
        checks++; if (state !== 3'd1 || input_val !== 7'd0 || done !== 1'b0) begin
            failures++; $display("FAIL priority state=%0d input_val=%0d done=%b exp=1/0/0", state, input_val, done);
        end
        keydown_start = 1'b0; keydown_clear = 1'b0; keydown_confirm = 1'b0; step();
    endtask

    task automatic test_max_val();
        press_start();
        press_num(4'd5);
        press_num(4'd7);
        checks++; if (input_val50 !== 7'd5) begin failures++; $display("FAIL max50_reject got=%0d exp=5", input_val50); end
        checks++; if (input_val !== 7'd57) begin failures++; $display("FAIL max99_57 got=%0d exp=57", input_val); end
        press_num(4'd0);
        checks++; if (input_val50 !== 7'd50) begin failures++; $display("FAIL max50_edge got=%0d exp=50", input_val50); end
        press_num(4'd9);
        press_num(4'd9);
        checks++; if (input_val !== 7'd99) begin failures++; $display("FAIL max99_edge got=%0d exp=99", input_val); end
        checks++; if (input_val50 !== 7'd9) begin failures++; $display("FAIL max50_99 got=%0d exp=9", input_val50); end
    endtask

    task automatic test_reset_midrun();
        press_confirm();
        pulse_tick();
        checks++; if (state !== 3'd2 || remaining !== 7'd98) begin
            failures++; $display("FAIL midrun state=%0d remaining=%0d exp=2/98", state, remaining);
        end
        rst = 1'b1; step();
        checks++; if (state !== 3'd0 || remaining !== 7'd0 || display !== 1'b0 || input_val !== 7'd0) begin
            failures++; $display("FAIL midrun_reset state=%0d remaining=%0d display=%b input_val=%0d exp=0/0/0/0",
                                 state, remaining, display, input_val);
        end
        rst = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_entry();
        test_run_to_expiry();
        test_pause_collision();
        test_priority_reload();
        test_max_val();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
